// File: rtl/dbg_pkg.sv
// Shared constants and encodings for the debug snapshot dump scheduler.
package dbg_pkg;

    localparam logic [7:0] TAG_PC  = 8'hA0;
    localparam logic [7:0] TAG_REG = 8'hA1;
    localparam logic [7:0] TAG_MEM = 8'hA2;

    typedef enum logic [1:0] {
        SEC_PC  = 2'd0,
        SEC_REG = 2'd1,
        SEC_MEM = 2'd2
    } section_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TAG     = 3'd1,
        ST_RD      = 3'd2,
        ST_LOAD    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    function automatic logic [7:0] section_tag(input section_e sec);
        case (sec)
            SEC_PC:  section_tag = TAG_PC;
            SEC_REG: section_tag = TAG_REG;
            default: section_tag = TAG_MEM;
        endcase
    endfunction

endpackage

// File: rtl/dbg_dump_sched.sv
// Serialises one MIPS snapshot (PC, register file, data memory) onto uart_tx,
// each section as a tag byte followed by 32-bit words sent MSB first.
module dbg_dump_sched
    import dbg_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int N_REGS      = 32,
    parameter int NB_MEM_ADDR = 7,
    parameter int N_MEM_WORDS = 128
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_pc,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0]     i_mem_data,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_done_tick,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [2:0]             o_state
);

    localparam int NB_WORD = (NB_REG_ADDR > NB_MEM_ADDR) ? NB_REG_ADDR : NB_MEM_ADDR;
    localparam logic [NB_WORD-1:0] LAST_REG = NB_WORD'(N_REGS - 1);
    localparam logic [NB_WORD-1:0] LAST_MEM = NB_WORD'(N_MEM_WORDS - 1);

    state_e               state_q, state_d;
    section_e             sec_q, sec_d;
    logic [NB_WORD-1:0]   word_q, word_d;
    logic [1:0]           byte_q, byte_d;
    logic [NB_DATA-1:0]   shift_q, shift_d;
    logic [NB_DATA-1:0]   pc_q, pc_d;
    logic                 after_tag_q, after_tag_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;

    logic                 last_word;
    logic                 tick_ok;
    logic                 addr_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sec_q       <= SEC_PC;
            word_q      <= '0;
            byte_q      <= '0;
            shift_q     <= '0;
            pc_q        <= '0;
            after_tag_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            shift_q     <= shift_d;
            pc_q        <= pc_d;
            after_tag_q <= after_tag_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    always_comb begin
        case (sec_q)
            SEC_PC:  last_word = 1'b1;
            SEC_REG: last_word = (word_q == LAST_REG);
            SEC_MEM: last_word = (word_q == LAST_MEM);
            default: last_word = 1'b1;
        endcase
    end

    // A tick coinciding with our own start pulse acknowledges the previous byte.
    assign tick_ok = i_tx_done_tick && !tx_start_q;

    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        word_d      = word_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
        pc_d        = pc_q;
        after_tag_d = after_tag_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    pc_d    = i_pc;
                    sec_d   = SEC_PC;
                    word_d  = '0;
                    byte_d  = '0;
                    state_d = ST_TAG;
                end
            end
            ST_TAG: begin
                tx_start_d  = 1'b1;
                tx_data_d   = section_tag(sec_q);
                after_tag_d = 1'b1;
                state_d     = ST_WAIT_TX;
            end
            ST_RD: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                case (sec_q)
                    SEC_PC:  shift_d = pc_q;
                    SEC_REG: shift_d = i_reg_data;
                    default: shift_d = i_mem_data;
                endcase
                byte_d  = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tx_start_d  = 1'b1;
                tx_data_d   = shift_q[NB_DATA-1 -: 8];
                after_tag_d = 1'b0;
                state_d     = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tick_ok) begin
                    if (after_tag_q) begin
                        state_d = (sec_q == SEC_PC) ? ST_LOAD : ST_RD;
                    end else if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shift_d = shift_q << 8;
                        state_d = ST_SEND;
                    end else if (!last_word) begin
                        word_d  = word_q + 1'b1;
                        state_d = ST_RD;
                    end else begin
                        case (sec_q)
                            SEC_PC: begin
                                sec_d   = SEC_REG;
                                word_d  = '0;
                                state_d = ST_TAG;
                            end
                            SEC_REG: begin
                                sec_d   = SEC_MEM;
                                word_d  = '0;
                                state_d = ST_TAG;
                            end
                            default: state_d = ST_DONE;
                        endcase
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address is held through LOAD so the synchronous read stays stable.
    assign addr_phase = (state_q == ST_RD) || (state_q == ST_LOAD);
    assign o_reg_addr = (addr_phase && sec_q == SEC_REG) ? word_q[NB_REG_ADDR-1:0] : '0;
    assign o_mem_addr = (addr_phase && sec_q == SEC_MEM) ? word_q[NB_MEM_ADDR-1:0] : '0;

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_done     = (state_q == ST_DONE);
    assign o_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_state    = state_q;

endmodule

// File: tb/tb_dbg_dump_sched.sv
// Bench for dbg_dump_sched: randomized snapshots, a byte-stream reference model,
// a responding uart_tx model and tick/start/reset disturbances.
module tb_dbg_dump_sched;
    import dbg_pkg::*;

    localparam int N_REGS = 2;
    localparam int N_MEM  = 2;
    localparam int NBYTES = 3 + 4 * (1 + N_REGS + N_MEM);

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_start = 1'b0;
    logic [31:0] i_pc = '0;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;
    logic [6:0]  o_mem_addr;
    logic [31:0] i_mem_data;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_done_tick;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_state;

    dbg_dump_sched #(
        .NB_DATA(32), .NB_REG_ADDR(5), .N_REGS(N_REGS),
        .NB_MEM_ADDR(7), .N_MEM_WORDS(N_MEM)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_pc(i_pc),
        .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
        .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_done_tick(i_tx_done_tick), .o_busy(o_busy), .o_done(o_done),
        .o_state(o_state)
    );

    // datapath debug ports: synchronous reads
    logic [31:0] regs [0:31];
    logic [31:0] mem  [0:127];
    always @(posedge clk) begin
        i_reg_data <= regs[o_reg_addr];
        i_mem_data <= mem[o_mem_addr];
    end

    // uart_tx model: done tick 10 cycles after each start
    int  tx_cnt;
    logic model_tick;
    logic inj_tick = 1'b0;
    bit   inj_en = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        tx_cnt <= 0;
        else if (o_tx_start) tx_cnt <= 10;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign model_tick = (tx_cnt == 1);
    assign i_tx_done_tick = model_tick | inj_tick;

    // stray ticks in IDLE/RD/LOAD and in the cycle of a start pulse
    always @(negedge clk) begin
        inj_tick = inj_en &&
                   (o_state == ST_IDLE || o_state == ST_RD || o_state == ST_LOAD || o_tx_start) &&
                   ($urandom_range(0, 1) == 1);
    end

    // scoreboard
    int checks = 0;
    int passed = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    endtask

    function automatic void push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (24 - 8 * b)) & 32'hFF));
    endfunction

    function automatic void build_exp(input logic [31:0] pc);
        exp_q.push_back(8'hA0);
        push_word(pc);
        exp_q.push_back(8'hA1);
        for (int i = 0; i < N_REGS; i++) push_word(regs[i]);
        exp_q.push_back(8'hA2);
        for (int i = 0; i < N_MEM; i++) push_word(mem[i]);
    endfunction

    // monitor: byte capture, done counting, address timing
    logic [4:0] reg_h [0:2];
    logic [6:0] mem_h [0:2];
    initial begin
        for (int i = 0; i < 3; i++) begin reg_h[i] = '0; mem_h[i] = '0; end
    end
    always @(negedge clk) begin
        int pos;
        if (o_tx_start) begin
            pos = got_q.size() % NBYTES;
            if (pos == 6 || pos == 10) begin
                chk($sformatf("reg_addr_rd_w%0d", (pos - 6) / 4), 32'(reg_h[2]), (pos - 6) / 4);
                chk($sformatf("reg_addr_ld_w%0d", (pos - 6) / 4), 32'(reg_h[1]), (pos - 6) / 4);
                chk("reg_addr_send_zero", 32'(reg_h[0]), 0);
            end
            if (pos == 15 || pos == 19) begin
                chk($sformatf("mem_addr_rd_w%0d", (pos - 15) / 4), 32'(mem_h[2]), (pos - 15) / 4);
                chk($sformatf("mem_addr_ld_w%0d", (pos - 15) / 4), 32'(mem_h[1]), (pos - 15) / 4);
                chk("mem_addr_send_zero", 32'(mem_h[0]), 0);
            end
            got_q.push_back(o_tx_data);
        end
        if (o_done) begin
            done_cnt++;
            chk("busy_low_on_done", o_busy, 0);
        end
        reg_h[2] = reg_h[1]; reg_h[1] = reg_h[0]; reg_h[0] = o_reg_addr;
        mem_h[2] = mem_h[1]; mem_h[1] = mem_h[0]; mem_h[0] = o_mem_addr;
    end

    // driver tasks
    task automatic randomize_snapshot();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
    endtask

    task automatic start_dump(input logic [31:0] pc);
        i_pc = pc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_accept", o_busy, 1);
        chk("no_tx_after_1", o_tx_start, 0);
        @(negedge clk);
        chk("tx_start_after_2", o_tx_start, 1);
        chk("first_tag", o_tx_data, 8'hA0);
    endtask

    task automatic wait_done();
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (o_done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_tx_start"}, o_tx_start, 0);
        chk({tag, "_tx_data"}, o_tx_data, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_reg_addr"}, o_reg_addr, 0);
        chk({tag, "_mem_addr"}, o_mem_addr, 0);
    endtask

    task automatic run_dump(input string tag, input logic [31:0] pc);
        int d0;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        start_dump(pc);
        wait_done();
        repeat (20) @(negedge clk);
        build_exp(pc);
        compare_stream(tag);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        bit seen;
        logic [31:0] pc;
        randomize_snapshot();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // fixed snapshot
        regs[0] = 32'h0; regs[1] = 32'hDEADBEEF;
        mem[0] = 32'h1;  mem[1] = 32'hCAFEF00D;
        run_dump("fixed", 32'h12345678);

        // second start mid-dump is ignored
        randomize_snapshot();
        pc = $urandom;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        start_dump(pc);
        repeat ($urandom_range(20, 150)) @(negedge clk);
        i_pc = $urandom; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        build_exp(pc);
        compare_stream("restart_ignored");
        chk("restart_done_once", done_cnt - d0, 1);

        // stray ticks
        randomize_snapshot();
        inj_en = 1'b1;
        repeat (6) @(negedge clk);
        run_dump("stray_ticks", $urandom);
        inj_en = 1'b0;
        @(negedge clk);

        // reset mid-dump
        randomize_snapshot();
        pc = $urandom;
        got_q.delete();
        d0 = done_cnt;
        start_dump(pc);
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            seen = (got_q.size() >= 9);
        end
        chk("reach_9th_byte", seen, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("abort_async");
        @(negedge clk);
        check_idle_outputs("abort_next");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_dump("after_abort", pc);

        // back-to-back dumps
        randomize_snapshot();
        pc = $urandom;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        start_dump(pc);
        wait_done();
        @(negedge clk);
        start_dump(pc);
        wait_done();
        repeat (20) @(negedge clk);
        build_exp(pc);
        build_exp(pc);
        compare_stream("back_to_back");
        chk("b2b_done_twice", done_cnt - d0, 2);

        // random snapshots, random stray ticks
        for (int k = 0; k < 3; k++) begin
            randomize_snapshot();
            inj_en = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(1, 5)) @(negedge clk);
            run_dump($sformatf("rand%0d", k), $urandom);
            inj_en = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
